// File: rtl/scandoubler.sv
`default_nettype none
// ============================================================================
// Module   : scandoubler
// Purpose  : Line doubler between native-rate (15 kHz) core video and the OSD.
//            Each input line is written into one bank of a two-bank line
//            buffer. The other bank is replayed twice at the full clk rate.
//            A fixed-width hsync is regenerated for every output line, vsync
//            is re-timed to input line starts, and every second output line
//            can be dimmed for a scanline effect.
// Ports    : clk        pixel clock, twice the input pixel rate
//            reset      synchronous, active-high
//            ce_in      input pixel strobe (nominally every 2nd clk)
//            scanlines  1 = dim odd output lines
//            r/g/b_in   6-bit input colour, sampled on ce_in
//            hs_in      input hsync, active-low
//            vs_in      input vsync, active-low
//            r/g/b_out  6-bit doubled colour
//            hs_out     regenerated hsync, active-low
//            vs_out     line-aligned vsync, active-low
// Revision : 1.0  initial release
// ============================================================================
module scandoubler #(
   parameter int HSYNC_LEN = 32,
   parameter int LINE_MAX  = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_in,
   input  logic       scanlines,
   input  logic [5:0] r_in,
   input  logic [5:0] g_in,
   input  logic [5:0] b_in,
   input  logic       hs_in,
   input  logic       vs_in,
   output logic [5:0] r_out,
   output logic [5:0] g_out,
   output logic [5:0] b_out,
   output logic       hs_out,
   output logic       vs_out
);

   localparam int            AW      = $clog2(LINE_MAX + 1);
   localparam logic [AW-1:0] IDX_MAX = AW'(LINE_MAX);
   localparam logic [AW-1:0] HS_END  = AW'(HSYNC_LEN);

   // Two banks of one line each, {r,g,b} per entry.
   logic [17:0]   line_mem [2][LINE_MAX+1];

   logic          hs_d;
   logic          wbank;
   logic          valid;
   logic          odd;
   logic [AW-1:0] in_hcnt;
   logic [AW-1:0] in_len;
   logic [AW-1:0] out_hcnt;

   logic          line_start;
   logic          wr_bank;
   logic [AW-1:0] wr_idx;

   // Output pipeline: stage 1 = RAM read, stage 2 = output register.
   logic [17:0]   rd_data;
   logic          sync_s1;
   logic          odd_s1;
   logic          dim;
   logic [5:0]    pix_r;
   logic [5:0]    pix_g;
   logic [5:0]    pix_b;

   assign line_start = ce_in && hs_d && !hs_in;

   // The pixel sampled on the line-start strobe is pixel 0 of the new line,
   // so the write goes to index 0 of the bank that is about to become active.
   // Past LINE_MAX the index sticks, so overlong lines keep overwriting the
   // last entry instead of wrapping onto the start of the line.
   always_comb begin
      wr_bank = wbank;
      wr_idx  = in_hcnt;
      if (line_start) begin
         wr_bank = ~wbank;
         wr_idx  = '0;
      end else if (in_hcnt != IDX_MAX) begin
         wr_idx  = in_hcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ce_in) begin
         line_mem[wr_bank][wr_idx] <= {r_in, g_in, b_in};
      end
   end

   // Input side: line length measurement and bank control.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_d    <= 1'b1;
         in_hcnt <= '0;
         in_len  <= '0;
         wbank   <= 1'b0;
         valid   <= 1'b0;
         vs_out  <= 1'b1;
      end else if (ce_in) begin
         hs_d    <= hs_in;
         in_hcnt <= wr_idx;
         if (line_start) begin
            in_len <= in_hcnt;
            wbank  <= ~wbank;
            vs_out <= vs_in;
            // The first line after reset has an unknown length; only a
            // line measured between two real line starts enables video.
            if (in_len != '0) begin
               valid <= 1'b1;
            end
         end
      end
   end

   // Output side: replay counter. Input line start overrides the wrap so
   // every input line produces exactly two output lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_hcnt <= '0;
         odd      <= 1'b0;
      end else if (line_start) begin
         out_hcnt <= '0;
         odd      <= 1'b0;
      end else if (out_hcnt == in_len) begin
         out_hcnt <= '0;
         odd      <= ~odd;
      end else begin
         out_hcnt <= out_hcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      rd_data <= line_mem[~wbank][out_hcnt];
   end

   // Sync and line parity travel alongside the RAM read so they stay
   // aligned with the pixel they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_s1 <= 1'b0;
         odd_s1  <= 1'b0;
      end else begin
         sync_s1 <= (out_hcnt < HS_END);
         odd_s1  <= odd;
      end
   end

   always_comb begin
      dim   = scanlines && odd_s1;
      pix_r = rd_data[17:12];
      pix_g = rd_data[11:6];
      pix_b = rd_data[5:0];
      if (dim) begin
         pix_r = {1'b0, rd_data[17:13]};
         pix_g = {1'b0, rd_data[11:7]};
         pix_b = {1'b0, rd_data[5:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !valid) begin
         r_out  <= '0;
         g_out  <= '0;
         b_out  <= '0;
         hs_out <= 1'b1;
      end else begin
         r_out  <= pix_r;
         g_out  <= pix_g;
         b_out  <= pix_b;
         hs_out <= ~sync_s1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scandoubler.sv
`default_nettype none
// ============================================================================
// Module   : tb_scandoubler
// Purpose  : Self-checking bench for scandoubler. Stimulus drives whole input
//            lines; every output sample is logged per clk and compared
//            against hand-computed vector tables relative to line starts.
// Revision : 1.0  initial release
// ============================================================================
module tb_scandoubler;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce_in;
   logic       scanlines;
   logic [5:0] r_in;
   logic [5:0] g_in;
   logic [5:0] b_in;
   logic       hs_in;
   logic       vs_in;
   logic [5:0] r_out;
   logic [5:0] g_out;
   logic [5:0] b_out;
   logic       hs_out;
   logic       vs_out;

   scandoubler #(.HSYNC_LEN(32), .LINE_MAX(1023)) dut (
      .clk       (clk),
      .reset     (reset),
      .ce_in     (ce_in),
      .scanlines (scanlines),
      .r_in      (r_in),
      .g_in      (g_in),
      .b_in      (b_in),
      .hs_in     (hs_in),
      .vs_in     (vs_in),
      .r_out     (r_out),
      .g_out     (g_out),
      .b_out     (b_out),
      .hs_out    (hs_out),
      .vs_out    (vs_out)
   );

   always #5 clk = ~clk;

   localparam int LOG_N = 65536;

   logic [5:0] log_r  [LOG_N];
   logic [5:0] log_g  [LOG_N];
   logic [5:0] log_b  [LOG_N];
   logic       log_hs [LOG_N];
   logic       log_vs [LOG_N];

   int   cyc     = 0;
   int   ls_cyc  [16];
   int   n_ls    = 0;
   int   rst_idx = 0;
   int   n_pass  = 0;
   int   n_total = 0;
   logic const_pix = 1'b0;

   // line = output line number after the reference input line start,
   // k = pixel index within that output line.
   typedef struct {
      int         line;
      int         k;
      logic [5:0] r;
      logic [5:0] g;
      logic [5:0] b;
      logic       hs;
   } vec_t;

   vec_t v_ramp  [11];
   vec_t v_blank [3];
   vec_t v_scan  [5];
   vec_t v_long  [6];
   vec_t v_stuck [5];

   // Sample on the falling edge, then return 1 ns after the rising edge so
   // the caller can drive the next inputs.
   task automatic tick_clk();
      @(negedge clk);
      if (cyc < LOG_N) begin
         log_r[cyc]  = r_out;
         log_g[cyc]  = g_out;
         log_b[cyc]  = b_out;
         log_hs[cyc] = hs_out;
         log_vs[cyc] = vs_out;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ce_in = 1'b0;
      hs_in = 1'b1;
      r_in  = '0;
      g_in  = '0;
      b_in  = '0;
      tick_clk();
      tick_clk();
      rst_idx = cyc - 1;
      reset = 1'b0;
      n_ls  = 0;
   endtask

   // Sends ticks t0..t1-1 of a line, ce on every 2nd clk, hsync low for
   // ticks 0-29. Ramp pixels: r = tick, g = tick ^ 3F, b = tick ^ 15.
   task automatic send_ticks(input int t0, input int t1);
      logic [5:0] p;
      for (int t = t0; t < t1; t++) begin
         if (t == 0 && n_ls < 16) begin
            ls_cyc[n_ls] = cyc;
            n_ls++;
         end
         p     = const_pix ? 6'h3F : t[5:0];
         r_in  = p;
         g_in  = const_pix ? p : (p ^ 6'h3F);
         b_in  = const_pix ? p : (p ^ 6'h15);
         hs_in = (t < 30) ? 1'b0 : 1'b1;
         ce_in = 1'b1;
         tick_clk();
         ce_in = 1'b0;
         tick_clk();
      end
   endtask

   // Output pixel k of the first replayed line is visible in the sample
   // taken three clk after the line-start strobe was driven.
   task automatic check_vec(input string tag, input int base, input int period,
                            input vec_t v);
      int idx;
      idx = base + 3 + v.line * period + v.k;
      n_total++;
      if (idx < 0 || idx >= cyc || idx >= LOG_N) begin
         $display("FAIL %s line%0d k%0d: sample %0d not captured, required < %0d",
                  tag, v.line, v.k, idx, cyc);
      end else if (log_r[idx] !== v.r || log_g[idx] !== v.g ||
                   log_b[idx] !== v.b || log_hs[idx] !== v.hs) begin
         $display("FAIL %s line%0d k%0d: got rgb=%h/%h/%h hs=%b, required rgb=%h/%h/%h hs=%b",
                  tag, v.line, v.k, log_r[idx], log_g[idx], log_b[idx], log_hs[idx],
                  v.r, v.g, v.b, v.hs);
      end else begin
         n_pass++;
      end
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         $display("FAIL %s: got %h, required %h", tag, act, req);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      v_ramp[0]  = '{0, 0,   6'h00, 6'h3F, 6'h15, 1'b0};
      v_ramp[1]  = '{0, 5,   6'h05, 6'h3A, 6'h10, 1'b0};
      v_ramp[2]  = '{0, 31,  6'h1F, 6'h20, 6'h0A, 1'b0};
      v_ramp[3]  = '{0, 32,  6'h20, 6'h1F, 6'h35, 1'b1};
      v_ramp[4]  = '{0, 63,  6'h3F, 6'h00, 6'h2A, 1'b1};
      v_ramp[5]  = '{0, 64,  6'h00, 6'h3F, 6'h15, 1'b1};
      v_ramp[6]  = '{0, 399, 6'h0F, 6'h30, 6'h1A, 1'b1};
      v_ramp[7]  = '{1, 0,   6'h00, 6'h3F, 6'h15, 1'b0};
      v_ramp[8]  = '{1, 31,  6'h1F, 6'h20, 6'h0A, 1'b0};
      v_ramp[9]  = '{1, 32,  6'h20, 6'h1F, 6'h35, 1'b1};
      v_ramp[10] = '{1, 399, 6'h0F, 6'h30, 6'h1A, 1'b1};

      v_blank[0] = '{0, 0,   6'h00, 6'h00, 6'h00, 1'b1};
      v_blank[1] = '{0, 200, 6'h00, 6'h00, 6'h00, 1'b1};
      v_blank[2] = '{1, 5,   6'h00, 6'h00, 6'h00, 1'b1};

      v_scan[0]  = '{0, 5,   6'h3F, 6'h3F, 6'h3F, 1'b0};
      v_scan[1]  = '{0, 200, 6'h3F, 6'h3F, 6'h3F, 1'b1};
      v_scan[2]  = '{1, 5,   6'h1F, 6'h1F, 6'h1F, 1'b0};
      v_scan[3]  = '{1, 200, 6'h1F, 6'h1F, 6'h1F, 1'b1};
      v_scan[4]  = '{1, 399, 6'h1F, 6'h1F, 6'h1F, 1'b1};

      v_long[0]  = '{0, 0,    6'h00, 6'h3F, 6'h15, 1'b0};
      v_long[1]  = '{0, 1,    6'h01, 6'h3E, 6'h14, 1'b0};
      v_long[2]  = '{0, 1022, 6'h3E, 6'h01, 6'h2B, 1'b1};
      v_long[3]  = '{0, 1023, 6'h0B, 6'h34, 6'h1E, 1'b1};
      v_long[4]  = '{1, 0,    6'h00, 6'h3F, 6'h15, 1'b0};
      v_long[5]  = '{1, 31,   6'h1F, 6'h20, 6'h0A, 1'b0};

      v_stuck[0] = '{5, 0,  6'h00, 6'h1F, 6'h0A, 1'b0};
      v_stuck[1] = '{5, 40, 6'h14, 6'h0B, 6'h1E, 1'b1};
      v_stuck[2] = '{8, 40, 6'h28, 6'h17, 6'h3D, 1'b1};
      v_stuck[3] = '{9, 31, 6'h0F, 6'h10, 6'h05, 1'b0};
      v_stuck[4] = '{9, 32, 6'h10, 6'h0F, 6'h1A, 1'b1};

      reset     = 1'b1;
      ce_in     = 1'b0;
      scanlines = 1'b0;
      hs_in     = 1'b1;
      vs_in     = 1'b1;
      r_in      = '0;
      g_in      = '0;
      b_in      = '0;
      @(posedge clk);
      #1;

      // 1: ramp lines of 400 ticks, plain doubling
      scanlines = 1'b0;
      const_pix = 1'b0;
      do_reset();
      check_eq("reset rgb", {14'd0, log_r[rst_idx], log_g[rst_idx], log_b[rst_idx]}, 32'd0);
      check_eq("reset hs/vs", {30'd0, log_hs[rst_idx], log_vs[rst_idx]}, 32'd3);
      for (int i = 0; i < 5; i++) send_ticks(0, 400);
      for (int i = 0; i < 3; i++) check_vec("t1 blank", ls_cyc[1], 400, v_blank[i]);
      for (int i = 0; i < 11; i++) check_vec("t1 ramp a", ls_cyc[2], 400, v_ramp[i]);
      for (int i = 0; i < 11; i++) check_vec("t1 ramp b", ls_cyc[3], 400, v_ramp[i]);
      check_eq("t1 hs before pixel0", {31'd0, log_hs[ls_cyc[3] + 2]}, 32'd1);

      // 2: scanline dimming on constant 3F
      scanlines = 1'b1;
      const_pix = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) send_ticks(0, 400);
      for (int i = 0; i < 5; i++) check_vec("t2 scan", ls_cyc[2], 400, v_scan[i]);

      // 3: 1100-tick lines saturate the line buffer index
      scanlines = 1'b0;
      const_pix = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) send_ticks(0, 1100);
      for (int i = 0; i < 6; i++) check_vec("t3 long", ls_cyc[2], 1024, v_long[i]);

      // 4: vsync changes mid-line
      do_reset();
      vs_in = 1'b1;
      for (int i = 0; i < 3; i++) send_ticks(0, 400);
      send_ticks(0, 200);
      begin
         int vs_cyc;
         vs_cyc = cyc;
         vs_in  = 1'b0;
         send_ticks(200, 400);
         send_ticks(0, 100);
         vs_in = 1'b1;
         send_ticks(100, 400);
         send_ticks(0, 10);
         check_eq("t4 vs held mid-line", {31'd0, log_vs[vs_cyc + 1]}, 32'd1);
      end
      check_eq("t4 vs before start", {31'd0, log_vs[ls_cyc[4]]}, 32'd1);
      check_eq("t4 vs at start", {31'd0, log_vs[ls_cyc[4] + 1]}, 32'd0);
      check_eq("t4 vs/hs aligned", {30'd0, log_vs[ls_cyc[4] + 3], log_hs[ls_cyc[4] + 3]}, 32'd0);
      check_eq("t4 vs rise before", {31'd0, log_vs[ls_cyc[5]]}, 32'd0);
      check_eq("t4 vs rise at start", {31'd0, log_vs[ls_cyc[5] + 1]}, 32'd1);

      // 5: one-clk reset pulse at tick 200
      vs_in = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) send_ticks(0, 400);
      send_ticks(0, 200);
      begin
         int rp;
         check_eq("t5 vs low pre-reset", {31'd0, log_vs[cyc - 1]}, 32'd0);
         rp    = cyc;
         reset = 1'b1;
         ce_in = 1'b0;
         tick_clk();
         reset = 1'b0;
         send_ticks(201, 400);
         send_ticks(0, 400);
         send_ticks(0, 400);
         send_ticks(0, 20);
         check_eq("t5 rgb after pulse", {14'd0, log_r[rp + 1], log_g[rp + 1], log_b[rp + 1]}, 32'd0);
         check_eq("t5 hs/vs after pulse", {30'd0, log_hs[rp + 1], log_vs[rp + 1]}, 32'd3);
         check_eq("t5 blank tail", {25'd0, log_hs[rp + 50], log_r[rp + 50]}, 32'h40);
      end
      for (int i = 0; i < 3; i++) check_vec("t5 blank", ls_cyc[4], 400, v_blank[i]);
      check_vec("t5 video", ls_cyc[5], 400, v_ramp[0]);
      check_vec("t5 video", ls_cyc[5], 400, v_ramp[1]);
      vs_in = 1'b1;

      // 6: ce_in stuck low after lock
      scanlines = 1'b1;
      const_pix = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) send_ticks(0, 400);
      ce_in = 1'b0;
      hs_in = 1'b1;
      for (int i = 0; i < 4000; i++) tick_clk();
      for (int i = 0; i < 5; i++) check_vec("t6 stuck", ls_cyc[3], 400, v_stuck[i]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scandoubler.md
Name: scandoubler

Overview:
- Line doubler between the core's native-rate video (15 kHz) and the OSD overlay stage.
- Buffers each incoming line and replays it twice at double pixel rate, giving VGA-rate (31 kHz) RGB666 plus syncs for the OSD.
- Regenerates a fixed-width hsync per output line and delays vsync to line boundaries.
- Optional scanline dimming on every second output line.

Parameters:
HSYNC_LEN, 32, output hsync low time in clk cycles
LINE_MAX, 1023, largest storable input pixel index; line buffer holds LINE_MAX+1 entries per bank

Ports:
clk  input  1  pixel clock at twice the input pixel rate; also drives the downstream OSD
reset  input  1  synchronous, active-high
ce_in  input  1  input pixel strobe, nominally every 2nd clk
scanlines  input  1  1 = dim odd output lines
r_in  input  6  input red, sampled on ce_in
g_in  input  6  input green
b_in  input  6  input blue
hs_in  input  1  input hsync, active-low
vs_in  input  1  input vsync, active-low
r_out  output  6  doubled red
g_out  output  6  doubled green
b_out  output  6  doubled blue
hs_out  output  1  regenerated hsync, active-low
vs_out  output  1  line-aligned vsync, active-low

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high.
- Reset values: r/g/b_out = 0, hs_out = 1, vs_out = 1, all counters 0, wbank = 0, in_len = 0, valid = 0, odd = 0.
- Input side acts only on cycles with ce_in = 1.
  - hs_in is registered as hs_d. A falling edge (hs_d = 1, hs_in = 0) is a line start.
  - At line start: in_len <= in_hcnt, in_hcnt <= 0, wbank toggles, vs_out <= vs_in, valid <= 1 if in_len was already nonzero.
  - Otherwise in_hcnt increments and saturates at LINE_MAX.
  - Every ce_in cycle writes {r_in, g_in, b_in} to buf[wbank][in_hcnt].
  - Writes at the saturated index overwrite entry LINE_MAX; no wrap.
- Output side acts every clk.
  - out_hcnt increments each cycle.
  - out_hcnt wraps to 0 when out_hcnt == in_len; the wrap toggles odd.
  - The input line-start event forces out_hcnt <= 0 and odd <= 0. This has priority over the wrap, so each input line yields exactly two output lines.
  - Read address is buf[~wbank][out_hcnt]. RAM read takes 1 cycle and the output register 1 more: RGB appears 2 clk after out_hcnt.
- hs_out = 0 while out_hcnt < HSYNC_LEN, else 1. It is delayed 2 clk to stay aligned with RGB.
- Blanking: if valid = 0, RGB out is 0 and hs_out is held 1.
- Scanlines: if scanlines = 1 and odd = 1, each channel is output as {1'b0, c[5:1]}. The odd value used is the one aligned with the pixel.
- Simultaneous ce_in line start and output wrap: line start wins; out_hcnt = 0, odd = 0.
- Reset asserted mid-line: everything returns to reset values on the next clk. valid needs two further input line starts before video resumes.
- ce_in stuck low: input state freezes. The output keeps replaying the last buffered line with period in_len.

Test Plan:
1. Reset, then 3 input lines of 400 ce_in ticks (ce every 2nd clk, hsync low for ticks 0-29), pixel value = tick index. Required: 2 blank lines, then out_hcnt period 400 clk; hs_out low for 32 clk per output line; output line pixel k = k, repeated twice per input line.
2. Same stimulus with scanlines = 1 and pixel 6'h3F. Required: first output line of each pair = 3F, second = 1F, on all channels.
3. Line length 1100 ticks. Required: in_len = 1023; index 1023 replays the last pixel written; no address wrap corruption.
4. vs_in falls mid-line. Required: vs_out changes only at the next input line start, and stays aligned with hs_out.
5. Reset pulsed for 1 clk at tick 200 of a line. Required: next clk r/g/b_out = 0, hs_out = 1, vs_out = 1; video returns only after two more line starts.
6. ce_in held low for 5 lines after lock at in_len = 400. Required: output repeats the last buffered line every 400 clk, with hs_out still pulsing.
